// File: rtl/ws2812_rx_decoder.sv
// WS2812 one-wire receiver: classifies high pulses into bits, assembles 24-bit GRB pixels, flags frame latch.
// Optional WS2812_RX_FWD_EN adds ws2812_data_out, which re-drives the line after the first pixel like a chained LED.
module ws2812_rx_decoder #(
  parameter int CNT_W        = 13,
  parameter int GLITCH_MIN   = 8,
  parameter int BIT_THRESH   = 48,
  parameter int MAX_HIGH     = 120,
  parameter int RESET_CYCLES = 4000,
  parameter int IDX_W        = 10
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             ws2812_data_in,
  output logic             pixel_rdy_out,
  output logic [23:0]      pixel_data_out,
  output logic [IDX_W-1:0] pixel_idx_out,
  output logic             frame_rdy_out,
  output logic [IDX_W-1:0] frame_len_out,
  output logic             err_out
`ifdef WS2812_RX_FWD_EN
  ,
  output logic             ws2812_data_out
`endif
);

  typedef enum logic [1:0] {S_WAIT_LATCH, S_IDLE, S_HIGH, S_LOW} state_e;

  localparam logic [CNT_W-1:0] GLITCH_C = CNT_W'(GLITCH_MIN);
  localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(BIT_THRESH);
  localparam logic [CNT_W-1:0] MAXHI_C  = CNT_W'(MAX_HIGH);
  localparam logic [CNT_W-1:0] RESET_C  = CNT_W'(RESET_CYCLES);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  logic             s0_q, s1_q, lvl_q, rise_q, fall_q;
  state_e           state_q;
  logic [CNT_W-1:0] hcnt_q, lcnt_q, lcnt_inc_d;
  logic [22:0]      shift_q;
  logic [23:0]      shift_d;
  logic [4:0]       bitcnt_q;
  logic [IDX_W-1:0] pixcnt_q;
  logic             hi_over_d, fall_ev_d, glitch_d, bit_ev_d, bit_d;
  logic             pix_done_d, ovf_d, latch_d, err_d;

  // Two-stage synchronizer, then a level/edge register aligned so rise_q/fall_q coincide with lvl_q
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      s0_q   <= 1'b0;
      s1_q   <= 1'b0;
      lvl_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      s0_q   <= ws2812_data_in;
      s1_q   <= s0_q;
      lvl_q  <= s1_q;
      rise_q <= s1_q & ~lvl_q;
      fall_q <= ~s1_q & lvl_q;
    end
  end

  always_comb begin
    lcnt_inc_d = sat_inc(lcnt_q);
    hi_over_d  = (state_q == S_HIGH) && (hcnt_q > MAXHI_C);
    fall_ev_d  = (state_q == S_HIGH) && !hi_over_d && fall_q;
    glitch_d   = fall_ev_d && (hcnt_q < GLITCH_C);
    bit_ev_d   = fall_ev_d && !glitch_d;
    bit_d      = hcnt_q > THRESH_C;
    shift_d    = {shift_q, bit_d};
    pix_done_d = bit_ev_d && (bitcnt_q == 5'd23);
    ovf_d      = pix_done_d && (pixcnt_q == '1);
    latch_d    = (state_q == S_LOW) && !rise_q && (lcnt_inc_d >= RESET_C);
    err_d      = hi_over_d || glitch_d || ovf_d || (latch_d && (bitcnt_q != 5'd0));
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q        <= S_WAIT_LATCH;
      hcnt_q         <= '0;
      lcnt_q         <= '0;
      shift_q        <= '0;
      bitcnt_q       <= '0;
      pixcnt_q       <= '0;
      pixel_rdy_out  <= 1'b0;
      pixel_data_out <= '0;
      pixel_idx_out  <= '0;
      frame_rdy_out  <= 1'b0;
      frame_len_out  <= '0;
      err_out        <= 1'b0;
    end else begin
      pixel_rdy_out <= pix_done_d;
      frame_rdy_out <= latch_d && (pixcnt_q != '0);
      err_out       <= err_d;
      case (state_q)
        // Refuse to decode until a full latch interval, so we never lock on mid-frame
        S_WAIT_LATCH: begin
          if (lvl_q) begin
            lcnt_q <= '0;
          end else if (lcnt_inc_d >= RESET_C) begin
            state_q  <= S_IDLE;
            lcnt_q   <= '0;
            shift_q  <= '0;
            bitcnt_q <= '0;
            pixcnt_q <= '0;
          end else begin
            lcnt_q <= lcnt_inc_d;
          end
        end
        S_IDLE: begin
          if (rise_q) begin
            state_q <= S_HIGH;
            hcnt_q  <= CNT_W'(1);
          end
        end
        S_HIGH: begin
          if (hi_over_d) begin
            state_q  <= S_WAIT_LATCH;
            lcnt_q   <= '0;
            bitcnt_q <= '0;
          end else if (fall_ev_d) begin
            state_q <= S_LOW;
            lcnt_q  <= CNT_W'(1);
            if (bit_ev_d) begin
              shift_q <= shift_d[22:0];
              if (pix_done_d) begin
                pixel_data_out <= shift_d;
                pixel_idx_out  <= pixcnt_q;
                bitcnt_q       <= '0;
                if (!ovf_d) pixcnt_q <= pixcnt_q + IDX_W'(1);
              end else begin
                bitcnt_q <= bitcnt_q + 5'd1;
              end
            end
          end else begin
            hcnt_q <= sat_inc(hcnt_q);
          end
        end
        S_LOW: begin
          if (rise_q) begin
            state_q <= S_HIGH;
            hcnt_q  <= CNT_W'(1);
          end else if (latch_d) begin
            state_q  <= S_IDLE;
            lcnt_q   <= '0;
            shift_q  <= '0;
            bitcnt_q <= '0;
            pixcnt_q <= '0;
            if (pixcnt_q != '0) frame_len_out <= pixcnt_q;
          end else begin
            lcnt_q <= lcnt_inc_d;
          end
        end
        default: state_q <= S_WAIT_LATCH;
      endcase
    end
  end

`ifdef WS2812_RX_FWD_EN
  logic fwd_en_q;

  // The gate only opens on a pixel-completing falling edge, so the line is low when forwarding starts
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      fwd_en_q        <= 1'b0;
      ws2812_data_out <= 1'b0;
    end else begin
      ws2812_data_out <= fwd_en_q & lvl_q;
      if (err_d || latch_d) fwd_en_q <= 1'b0;
      else if (pix_done_d && (pixcnt_q == '0)) fwd_en_q <= 1'b1;
    end
  end
`endif

endmodule
